pxs_ball_mover: RTL and testbench
=================================

// Module: pxs_ball_mover
// PURPOSE
//  Upstream companion of the ball-drawing stage. Generates the ball's pos_x/pos_y.
//  Taps the VS bit of the pixel stream and advances the ball once per step frame.
//  Reflects the ball off the four screen edges and pulses a flag on each bounce.
//  Updates land in a few cycles after VS rises, inside vertical blank, so no frame tears.
// PARAMETERS
//  H_ACTIVE        640  visible width in pixels
//  V_ACTIVE        480  visible height in lines
//  SIZE_BALL       10   ball side; must equal the draw stage's size_ball
//  SPEED_X         2    x step per move (1..15)
//  SPEED_Y         1    y step per move (1..15)
//  INIT_X          315  x position after reset
//  INIT_Y          235  y position after reset
//  FRAMES_PER_STEP 1    frames between moves (1..255)
// PORTS
//  px_clk    in   1   pixel clock; the only clock
//  reset_n   in   1   reset, synchronous, active-low
//  RGBStr_i  in   26  pixel stream; only bit 1 (VS) is used
//  pause     in   1   1 = freeze the ball (frame ticks ignored)
//  pos_x     out  10  ball x (left edge), feeds the draw stage
//  pos_y     out  10  ball y (top edge), feeds the draw stage
//  dir_x     out  1   1 = moving +x, 0 = moving -x
//  dir_y     out  1   1 = moving +y, 0 = moving -y
//  hit_x     out  1   1-cycle pulse on a left/right wall bounce
//  hit_y     out  1   1-cycle pulse on a top/bottom wall bounce
// BEHAVIOUR
//  Reset (reset_n=0 at a px_clk edge): pos_x=INIT_X, pos_y=INIT_Y, dir_x=1, dir_y=1,
//   hit_x=hit_y=0, frame counter=0, vs_d=0, state=S_WAIT. Applies from any state.
//  Tick: tick=VS & ~vs_d, with vs_d = VS registered. One tick per VS rising edge.
//  Frame counter (8b): counts ticks while pause=0.
//   - If cnt==FRAMES_PER_STEP-1: cnt wraps to 0 and the FSM enters S_MOVE_X.
//   - Otherwise cnt increments.
//   - pause=1: the counter holds and the FSM stays in S_WAIT.
//  FSM: S_WAIT -> S_MOVE_X -> S_MOVE_Y -> S_WAIT, one cycle each.
//   Ticks seen in the MOVE states are dropped.
//  Latency: tick on cycle N. pos_x updates at edge N+1, pos_y at edge N+2.
//   Both are stable from N+3 until the next move.
//  Arithmetic: 12-bit signed nxt = pos +/- SPEED; limit MAX_X=H_ACTIVE-SIZE_BALL, MAX_Y likewise.
//   - nxt<0: pos=0, dir:=1, hit pulse.
//   - nxt>MAX: pos=MAX, dir:=0, hit pulse.
//   - 0<=nxt<=MAX: pos=nxt, no bounce. Landing exactly on 0 or MAX is not a bounce.
//  hit_x is high only in the cycle after S_MOVE_X; hit_y only in the cycle after S_MOVE_Y.
//  A corner bounce gives hit_x and hit_y on consecutive cycles.
//  pause rising mid-move: the current X/Y sequence completes; the next tick is ignored.
//  Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Stream field aliases (VS 1:1, Active 0:0, XC, YC, RGB) go in a shared include,
//   pxs_stream.vh. This block and the draw stage use the same definitions.
//  Sub-module pxs_frame_tick: VS register plus rising-edge detector, reused by later stages.
//  Axis update is one function (pos, dir, speed, max) -> (pos, dir, hit), called for X and for Y.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles -> pos=(315,235), dir=(1,1), no hit pulses.
//  2 Free move: default params, 3 VS rising edges -> pos=(321,238); each update 1-2 cycles after the tick.
//  3 Right wall: pos_x=629, dir_x=1, SPEED_X=2 -> pos_x=630, dir_x=0, hit_x=1 for one cycle.
//    Next tick -> pos_x=628.
//  4 Exact edge: pos_y=469, SPEED_Y=1, dir_y=1 -> pos_y=470, dir_y stays 1, no hit.
//    Next tick -> pos_y=470, dir_y=0, hit_y.
//  5 Pause/divider: FRAMES_PER_STEP=3, pause=0 -> one move per 3 ticks.
//    pause=1 for 5 ticks -> pos and counter frozen.
//  6 Reset mid-move: assert reset_n=0 in the S_MOVE_X cycle -> reset values, pos_y not updated.

Source files
------------

// File: rtl/pxs_ball_mover_pkg.sv
// Shared definitions for the ball mover: stream field positions, FSM states and
// the per-axis reflection step used for both X and Y.
package pxs_ball_mover_pkg;

  // Pixel stream field positions, shared with the draw stage
  localparam int unsigned STREAM_W   = 26;
  localparam int unsigned VS_BIT     = 1;
  localparam int unsigned ACTIVE_BIT = 0;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One step along an axis; overshooting either wall clamps to the wall and reverses.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [3:0] speed, input logic [9:0] max);
    axis_t             r;
    logic signed [11:0] nxt;
    nxt = dir ? $signed({2'b00, pos}) + $signed({8'b0, speed})
              : $signed({2'b00, pos}) - $signed({8'b0, speed});
    if (nxt < 12'sd0) begin
      r.pos = '0;
      r.dir = 1'b1;
      r.hit = 1'b1;
    end else if (nxt > $signed({2'b00, max})) begin
      r.pos = max;
      r.dir = 1'b0;
      r.hit = 1'b1;
    end else begin
      r.pos = nxt[9:0];
      r.dir = dir;
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pxs_ball_mover_frame_tick.sv
// Registers VS and flags its rising edge; one tick per frame.
module pxs_frame_tick (
  input  logic clk,
  input  logic reset_n,
  input  logic vs,
  output logic tick
);

  logic vs_d;

  always_ff @(posedge clk) begin
    if (!reset_n) vs_d <= 1'b0;
    else          vs_d <= vs;
  end

  assign tick = vs & ~vs_d;

endmodule

// File: rtl/pxs_ball_mover.sv
// Ball position generator: advances the ball once per step frame inside vertical
// blank, reflecting off the screen edges and pulsing a flag per bounce.
module pxs_ball_mover
  import pxs_ball_mover_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned SIZE_BALL       = 10,
  parameter int unsigned SPEED_X         = 2,
  parameter int unsigned SPEED_Y         = 1,
  parameter int unsigned INIT_X          = 315,
  parameter int unsigned INIT_Y          = 235,
  parameter int unsigned FRAMES_PER_STEP = 1
) (
  input  logic                px_clk,
  input  logic                reset_n,
  input  logic [STREAM_W-1:0] RGBStr_i,
  input  logic                pause,
  output logic [9:0]          pos_x,
  output logic [9:0]          pos_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic                hit_x,
  output logic                hit_y
);

  localparam logic [9:0] MAX_X    = 10'(H_ACTIVE - SIZE_BALL);
  localparam logic [9:0] MAX_Y    = 10'(V_ACTIVE - SIZE_BALL);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       tick;
  axis_t      nxt_x;
  axis_t      nxt_y;
  logic       stream_unused;

  assign stream_unused = ^{RGBStr_i[STREAM_W-1:VS_BIT+1], RGBStr_i[ACTIVE_BIT]};

  pxs_frame_tick u_frame_tick (
    .clk     (px_clk),
    .reset_n (reset_n),
    .vs      (RGBStr_i[VS_BIT]),
    .tick    (tick)
  );

  assign nxt_x = axis_step(pos_x, dir_x, 4'(SPEED_X), MAX_X);
  assign nxt_y = axis_step(pos_y, dir_y, 4'(SPEED_Y), MAX_Y);

  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      cnt   <= '0;
      pos_x <= 10'(INIT_X);
      pos_y <= 10'(INIT_Y);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      hit_x <= 1'b0;
      hit_y <= 1'b0;
    end else begin
      hit_x <= 1'b0;
      hit_y <= 1'b0;
      case (state)
        S_WAIT: begin
          if (tick && !pause) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_MOVE_X;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_MOVE_X: begin
          pos_x <= nxt_x.pos;
          dir_x <= nxt_x.dir;
          hit_x <= nxt_x.hit;
          state <= S_MOVE_Y;
        end
        S_MOVE_Y: begin
          pos_y <= nxt_y.pos;
          dir_y <= nxt_y.dir;
          hit_y <= nxt_y.hit;
          state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pxs_ball_mover.sv
// Bench for pxs_ball_mover: two instances (step every frame, step every 3rd frame)
// driven by random VS/pause traffic and checked against a frame-level model.
module tb_pxs_ball_mover;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic [25:0] stream = '0;

  logic [9:0] pos_x0, pos_y0, pos_x1, pos_y1;
  logic       dir_x0, dir_y0, hit_x0, hit_y0;
  logic       dir_x1, dir_y1, hit_x1, hit_y1;

  always #5 clk = ~clk;

  pxs_ball_mover #(.FRAMES_PER_STEP(1)) u_dut0 (
    .px_clk(clk), .reset_n(reset_n), .RGBStr_i(stream), .pause(pause),
    .pos_x(pos_x0), .pos_y(pos_y0), .dir_x(dir_x0), .dir_y(dir_y0),
    .hit_x(hit_x0), .hit_y(hit_y0)
  );

  pxs_ball_mover #(.FRAMES_PER_STEP(3)) u_dut1 (
    .px_clk(clk), .reset_n(reset_n), .RGBStr_i(stream), .pause(pause),
    .pos_x(pos_x1), .pos_y(pos_y1), .dir_x(dir_x1), .dir_y(dir_y1),
    .hit_x(hit_x1), .hit_y(hit_y1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: ball state and step divider per instance
  int fps[2] = '{1, 3};
  int mx[2], my[2], mdx[2], mdy[2], mcnt[2];
  localparam int MAX_X = 630;
  localparam int MAX_Y = 470;

  function automatic logic [23:0] pack(int x, int y, int dx, int dy, int hx, int hy);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    return {xv, yv, dx != 0, dy != 0, hx != 0, hy != 0, 2'b00};
  endfunction

  task automatic check(input string tag, input int i, input logic [23:0] exp);
    logic [23:0] obs;
    obs = (i == 0) ? {pos_x0, pos_y0, dir_x0, dir_y0, hit_x0, hit_y0, 2'b00}
                   : {pos_x1, pos_y1, dir_x1, dir_y1, hit_x1, hit_y1, 2'b00};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s inst%0d observed={x,y,dx,dy,hx,hy,00}=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic axis(input int p, input int d, input int sp, input int lim,
                      output int np, output int nd, output int hit);
    int n;
    n = d ? p + sp : p - sp;
    if (n < 0) begin
      np = 0; nd = 1; hit = 1;
    end else if (n > lim) begin
      np = lim; nd = 0; hit = 1;
    end else begin
      np = n; nd = d; hit = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 315; my[i] = 235; mdx[i] = 1; mdy[i] = 1; mcnt[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One VS rising edge; checks both instances on the three edges after the tick.
  // glitch adds a second VS rise that lands while the instances are mid-move.
  task automatic frame(input bit p, input bit glitch);
    int mv[2], nx[2], ndx[2], hx[2], ny[2], ndy[2], hy[2];
    pause = p;
    stream[1] = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0;
      if (!p) begin
        if (mcnt[i] == fps[i] - 1) begin
          mcnt[i] = 0;
          mv[i] = 1;
        end else begin
          mcnt[i]++;
        end
      end
      if (mv[i] != 0) begin
        axis(mx[i], mdx[i], 2, MAX_X, nx[i], ndx[i], hx[i]);
        axis(my[i], mdy[i], 1, MAX_Y, ny[i], ndy[i], hy[i]);
      end else begin
        nx[i] = mx[i]; ndx[i] = mdx[i]; hx[i] = 0;
        ny[i] = my[i]; ndy[i] = mdy[i]; hy[i] = 0;
      end
    end
    if (glitch) stream[1] = 1'b0;
    step();
    for (int i = 0; i < 2; i++)
      check("move_x", i, pack(nx[i], my[i], ndx[i], mdy[i], hx[i], 0));
    stream[1] = glitch;
    step();
    for (int i = 0; i < 2; i++)
      check("move_y", i, pack(nx[i], ny[i], ndx[i], ndy[i], 0, hy[i]));
    stream[1] = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      check("settled", i, pack(nx[i], ny[i], ndx[i], ndy[i], 0, 0));
      mx[i] = nx[i]; mdx[i] = ndx[i]; my[i] = ny[i]; mdy[i] = ndy[i];
    end
    step();
  endtask

  initial begin
    bit p, g;
    model_reset();

    // Reset held for two cycles
    reset_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) check("reset", i, pack(315, 235, 1, 1, 0, 0));
    reset_n = 1'b1;
    step();

    // Three frames with no pause
    for (int k = 0; k < 3; k++) frame(1'b0, 1'b0);
    check("free_move", 0, pack(321, 238, 1, 1, 0, 0));
    check("divided_move", 1, pack(317, 236, 1, 1, 0, 0));

    // Reset arriving in the X-move cycle wins; Y must not move afterwards
    stream[1] = 1'b1;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    stream[1] = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) check("reset_mid_move", i, pack(315, 235, 1, 1, 0, 0));
    step();
    step();
    for (int i = 0; i < 2; i++) check("after_reset_mid_move", i, pack(315, 235, 1, 1, 0, 0));

    // Long random run: covers both walls on both axes, pause and dropped ticks
    for (int k = 0; k < 700; k++) begin
      p = ($urandom_range(0, 4) == 0);
      g = (!p && mcnt[1] == 2 && $urandom_range(0, 3) == 0);
      frame(p, g);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
